// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shifter
//  Purpose  : Multi-cycle barrel-shift replacement; STEP bits per clock,
//             arithmetic/logical/rotate, signed amount. Optional carry output
//             enabled by defining SEQ_SHIFTER_CARRY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 6,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SEQ_SHIFTER_CARRY_EN
  ,
  output logic             carry
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int EXT_W = (AMT_W + 1 > CNT_W) ? AMT_W + 1 : CNT_W;
  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic             r_msb;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_neg;
  logic [AMT_W:0]   w_amt_ext;
  logic [AMT_W:0]   w_mag;
  logic [EXT_W-1:0] w_mag_ext;
  logic [CNT_W-1:0] w_count;
  logic [WIDTH-1:0] w_work_n;
  logic [CNT_W-1:0] w_rem_n;
  logic             w_bit;
  logic             w_fill;
  logic             w_last;

  // Magnitude is one bit wider so the most negative amount stays representable.
  assign w_neg     = amount[AMT_W-1];
  assign w_amt_ext = {amount[AMT_W-1], amount};
  assign w_mag     = w_neg ? -w_amt_ext : w_amt_ext;
  assign w_mag_ext = EXT_W'(w_mag);

  always_comb begin
    w_count = '0;
    if (mode == MODE_ROT)
      w_count = CNT_W'(w_mag_ext & EXT_W'(WIDTH - 1));
    else if (w_mag_ext >= EXT_W'(WIDTH))
      w_count = CNT_W'(WIDTH);
    else
      w_count = CNT_W'(w_mag_ext);
  end

  // Up to STEP single-bit shifts, each gated by the bits still remaining.
  always_comb begin
    w_work_n = r_work;
    w_bit    = 1'b0;
    w_fill   = 1'b0;
    w_last   = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (CNT_W'(i) < r_rem) begin
        w_bit = r_dir ? w_work_n[0] : w_work_n[WIDTH-1];
        if (r_mode == MODE_ROT)
          w_fill = w_bit;
        else if (r_mode == MODE_ARITH && r_dir)
          w_fill = r_msb;
        else
          w_fill = 1'b0;
        if (r_dir)
          w_work_n = {w_fill, w_work_n[WIDTH-1:1]};
        else
          w_work_n = {w_work_n[WIDTH-2:0], w_fill};
        w_last = w_bit;
      end
    end
  end

  assign w_rem_n = (r_rem > CNT_W'(STEP)) ? r_rem - CNT_W'(STEP) : '0;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_state_n = (w_count == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_rem_n == '0)
          w_state_n = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start)
          w_state_n = (w_count == '0) ? S_DONE : S_SHIFT;
        else
          w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

`ifdef SEQ_SHIFTER_CARRY_EN
  logic r_cout;
  logic r_carry;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work   <= '0;
      r_rem    <= '0;
      r_dir    <= 1'b0;
      r_mode   <= 2'b00;
      r_msb    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
`ifdef SEQ_SHIFTER_CARRY_EN
      r_cout   <= 1'b0;
      r_carry  <= 1'b0;
`endif
    end else if (r_state == S_SHIFT) begin
      r_work <= w_work_n;
      r_rem  <= w_rem_n;
`ifdef SEQ_SHIFTER_CARRY_EN
      r_cout <= w_last;
`endif
      if (w_rem_n == '0) begin
        r_result <= w_work_n;
        r_zero   <= (w_work_n == '0);
`ifdef SEQ_SHIFTER_CARRY_EN
        r_carry  <= w_last;
`endif
      end
    end else if (start) begin
      r_work <= src;
      r_rem  <= w_count;
      r_dir  <= w_neg;
      r_mode <= mode;
      r_msb  <= src[WIDTH-1];
`ifdef SEQ_SHIFTER_CARRY_EN
      r_cout <= 1'b0;
`endif
      if (w_count == '0) begin
        r_result <= src;
        r_zero   <= (src == '0);
`ifdef SEQ_SHIFTER_CARRY_EN
        r_carry  <= 1'b0;
`endif
      end
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
`ifdef SEQ_SHIFTER_CARRY_EN
  assign carry  = r_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_shifter
//  Purpose  : Directed self-checking bench for seq_shifter (STEP=1 and STEP=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, busy, done, zero;
  logic [15:0] src = '0, result;
  logic [5:0]  amount = '0;
  logic [1:0]  mode = '0;

  logic        start4 = 1'b0, busy4, done4, zero4;
  logic [15:0] src4 = '0, result4;
  logic [5:0]  amount4 = '0;
  logic [1:0]  mode4 = '0;

`ifdef SEQ_SHIFTER_CARRY_EN
  logic carry, carry4;
`endif

  int n_vec = 0;
  int n_err = 0;

  seq_shifter #(.WIDTH(16), .AMT_W(6), .STEP(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .amount(amount),
    .mode(mode), .busy(busy), .done(done), .result(result), .zero(zero)
`ifdef SEQ_SHIFTER_CARRY_EN
    , .carry(carry)
`endif
  );

  seq_shifter #(.WIDTH(16), .AMT_W(6), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .src(src4), .amount(amount4),
    .mode(mode4), .busy(busy4), .done(done4), .result(result4), .zero(zero4)
`ifdef SEQ_SHIFTER_CARRY_EN
    , .carry(carry4)
`endif
  );

  // Launch one operation and count clocks until done (-1 on timeout).
  task automatic run_op(input bit sel4, input logic [15:0] s, input logic [5:0] a,
                        input logic [1:0] m, output int clocks, output int busy_cyc);
    @(negedge clk);
    if (sel4) begin src4 = s; amount4 = a; mode4 = m; start4 = 1'b1; end
    else      begin src  = s; amount  = a; mode  = m; start  = 1'b1; end
    clocks = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0; start4 = 1'b0;
      if (sel4 ? done4 : done) begin clocks = k; break; end
      if (sel4 ? busy4 : busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done); end
    n_vec++; if (result !== 16'h0000 || zero !== 1'b1) begin n_err++;
      $display("FAIL reset_result: result=%h zero=%b expected 0000 1", result, zero); end
    n_vec++; if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== 16'h0000 || zero4 !== 1'b1) begin n_err++;
      $display("FAIL reset_step4: busy=%b done=%b result=%h zero=%b expected 0 0 0000 1",
               busy4, done4, result4, zero4); end
`ifdef SEQ_SHIFTER_CARRY_EN
    n_vec++; if (carry !== 1'b0 || carry4 !== 1'b0) begin n_err++;
      $display("FAIL reset_carry: got %b%b expected 00", carry, carry4); end
`endif
  endtask

  task automatic test_logical();
    int c, b;
    run_op(1'b0, 16'hFFFF, 6'h3F, 2'b01, c, b);
    n_vec++; if (result !== 16'h7FFF || c !== 2 || b !== 1) begin n_err++;
      $display("FAIL lsr1: result=%h clocks=%0d busy=%0d expected 7fff 2 1", result, c, b); end
`ifdef SEQ_SHIFTER_CARRY_EN
    n_vec++; if (carry !== 1'b1) begin n_err++;
      $display("FAIL lsr1_carry: got %b expected 1", carry); end
`endif
    run_op(1'b0, 16'h00F0, 6'h04, 2'b11, c, b);
    n_vec++; if (result !== 16'h0F00 || c !== 5) begin n_err++;
      $display("FAIL mode11_lsl4: result=%h clocks=%0d expected 0f00 5", result, c); end
    run_op(1'b0, 16'h1234, 6'h00, 2'b01, c, b);
    n_vec++; if (result !== 16'h1234 || c !== 1 || zero !== 1'b0) begin n_err++;
      $display("FAIL amt0: result=%h clocks=%0d zero=%b expected 1234 1 0", result, c, zero); end
  endtask

  task automatic test_arith();
    int c, b;
    run_op(1'b0, 16'h8000, 6'h3F, 2'b00, c, b);
    n_vec++; if (result !== 16'hC000 || c !== 2) begin n_err++;
      $display("FAIL asr1: result=%h clocks=%0d expected c000 2", result, c); end
    run_op(1'b0, 16'h8000, 6'h30, 2'b00, c, b);
    n_vec++; if (result !== 16'hFFFF || c !== 17) begin n_err++;
      $display("FAIL asr16: result=%h clocks=%0d expected ffff 17", result, c); end
    run_op(1'b0, 16'h8000, 6'h20, 2'b00, c, b);
    n_vec++; if (result !== 16'hFFFF || c !== 17) begin n_err++;
      $display("FAIL asr_minneg: result=%h clocks=%0d expected ffff 17", result, c); end
    run_op(1'b0, 16'h8000, 6'h01, 2'b00, c, b);
    n_vec++; if (result !== 16'h0000 || zero !== 1'b1 || c !== 2) begin n_err++;
      $display("FAIL asl1: result=%h zero=%b clocks=%0d expected 0000 1 2", result, zero, c); end
  endtask

  task automatic test_rotate();
    int c, b;
    run_op(1'b0, 16'h8001, 6'h04, 2'b10, c, b);
    n_vec++; if (result !== 16'h0018 || c !== 5) begin n_err++;
      $display("FAIL rol4: result=%h clocks=%0d expected 0018 5", result, c); end
    run_op(1'b0, 16'h8001, 6'h2C, 2'b10, c, b);
    n_vec++; if (result !== 16'h1800 || c !== 5) begin n_err++;
      $display("FAIL ror20: result=%h clocks=%0d expected 1800 5", result, c); end
    run_op(1'b0, 16'h8001, 6'h10, 2'b10, c, b);
    n_vec++; if (result !== 16'h8001 || c !== 1) begin n_err++;
      $display("FAIL rol16: result=%h clocks=%0d expected 8001 1", result, c); end
  endtask

  task automatic test_back_to_back();
    int c = -1;
    int extra = 0;
    @(negedge clk);
    src = 16'hFFFF; amount = 6'h1F; mode = 2'b01; start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 3) begin src = 16'h5555; amount = 6'h00; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) begin c = k; break; end
    end
    n_vec++; if (result !== 16'h0000 || zero !== 1'b1 || c !== 17) begin n_err++;
      $display("FAIL sat_lsl31: result=%h zero=%b clocks=%0d expected 0000 1 17", result, zero, c); end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_vec++; if (extra !== 0 || result !== 16'h0000) begin n_err++;
      $display("FAIL busy_start_ignored: extra_done=%0d result=%h expected 0 0000", extra, result); end
  endtask

  task automatic test_reset_mid();
    int c, b;
    run_op(1'b0, 16'h1234, 6'h00, 2'b01, c, b);
    @(negedge clk);
    src = 16'hABCD; amount = 6'h36; mode = 2'b01; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || zero !== 1'b1) begin n_err++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h zero=%b expected 0 0 0000 1",
               busy, done, result, zero); end
    reset = 1'b0;
    run_op(1'b0, 16'h00F0, 6'h3C, 2'b01, c, b);
    n_vec++; if (result !== 16'h000F || c !== 5) begin n_err++;
      $display("FAIL after_reset_lsr4: result=%h clocks=%0d expected 000f 5", result, c); end
  endtask

  task automatic test_step4();
    int c, b;
    run_op(1'b1, 16'h1234, 6'h08, 2'b01, c, b);
    n_vec++; if (result4 !== 16'h3400 || c !== 3 || b !== 2) begin n_err++;
      $display("FAIL s4_lsl8: result=%h clocks=%0d busy=%0d expected 3400 3 2", result4, c, b); end
`ifdef SEQ_SHIFTER_CARRY_EN
    n_vec++; if (carry4 !== 1'b0) begin n_err++;
      $display("FAIL s4_lsl8_carry: got %b expected 0", carry4); end
`endif
    run_op(1'b1, 16'h1234, 6'h3D, 2'b00, c, b);
    n_vec++; if (result4 !== 16'h0246 || c !== 2) begin n_err++;
      $display("FAIL s4_asr3: result=%h clocks=%0d expected 0246 2", result4, c); end
`ifdef SEQ_SHIFTER_CARRY_EN
    n_vec++; if (carry4 !== 1'b1) begin n_err++;
      $display("FAIL s4_asr3_carry: got %b expected 1", carry4); end
`endif
    run_op(1'b1, 16'h8000, 6'h3B, 2'b00, c, b);
    n_vec++; if (result4 !== 16'hFC00 || c !== 3) begin n_err++;
      $display("FAIL s4_asr5: result=%h clocks=%0d expected fc00 3", result4, c); end
    run_op(1'b1, 16'h1234, 6'h0C, 2'b10, c, b);
    n_vec++; if (result4 !== 16'h4123 || c !== 4) begin n_err++;
      $display("FAIL s4_rol12: result=%h clocks=%0d expected 4123 4", result4, c); end
`ifdef SEQ_SHIFTER_CARRY_EN
    n_vec++; if (carry4 !== 1'b1) begin n_err++;
      $display("FAIL s4_rol12_carry: got %b expected 1", carry4); end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_logical();
    test_arith();
    test_rotate();
    test_back_to_back();
    test_reset_mid();
    test_step4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
